// File: rtl/flow_pkg.sv
// rtl/flow_pkg.sv - shared flow defaults, tag width helper and tagged-word type
package flow_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int FLUX_DEF   = 2;

    // Tag width never collapses to zero, even for a single flow.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int TAG_W_DEF = clog2(FLUX_DEF);

    typedef logic [TAG_W_DEF-1:0] tag_t;

    typedef struct packed {
        tag_t                  tag;
        logic [DATA_W_DEF-1:0] data;
    } tagged_word_t;

endpackage

// File: rtl/flow_demux_reader_if.sv
// rtl/flow_demux_reader_if.sv - tagged write, frame config and per-flow read signals
interface flow_demux_reader_if
    import flow_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FLUX   = FLUX_DEF,
    parameter int CNT_W  = 16,
    parameter int TAG_W  = clog2(FLUX)
);
    logic [TAG_W+DATA_W-1:0] wr_din;
    logic                    wr_write;
    logic [FLUX-1:0]         wr_full;
    logic [TAG_W+CNT_W-1:0]  cfg_din;
    logic                    cfg_write;
    logic [FLUX*DATA_W-1:0]  rd_dout;
    logic [FLUX-1:0]         rd_empty;
    logic [FLUX-1:0]         rd_read;
    logic [FLUX-1:0]         frame_done;
    logic                    err;

    modport master (
        output wr_din, wr_write, cfg_din, cfg_write, rd_read,
        input  wr_full, rd_dout, rd_empty, frame_done, err
    );

    modport slave (
        input  wr_din, wr_write, cfg_din, cfg_write, rd_read,
        output wr_full, rd_dout, rd_empty, frame_done, err
    );
endinterface

// File: rtl/flow_fifo.sv
// rtl/flow_fifo.sv - single-flow show-ahead FIFO with occupancy count
module flow_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Storage is left unreset, so the head is forced to zero while empty.
    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/flow_demux_reader.sv
// rtl/flow_demux_reader.sv - tag demux into per-flow FIFOs with frame counters and error flag
module flow_demux_reader
    import flow_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FLUX   = FLUX_DEF,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16,
    parameter int TAG_W  = clog2(FLUX)
) (
    input logic                clk,
    input logic                rst,
    flow_demux_reader_if.slave bus
);
    logic [TAG_W-1:0]             wr_tag;
    logic [DATA_W-1:0]            wr_data;
    logic [TAG_W-1:0]             cfg_tag;
    logic [CNT_W-1:0]             cfg_len;
    logic [FLUX-1:0]              accept;
    logic [FLUX-1:0]              cfg_hit;
    logic [FLUX-1:0]              full;
    logic [FLUX-1:0]              empty;
    logic [FLUX-1:0]              done_q;
    logic [FLUX-1:0][DATA_W-1:0]  head;
    logic                         err_q;

    assign wr_tag  = bus.wr_din[TAG_W+DATA_W-1:DATA_W];
    assign wr_data = bus.wr_din[DATA_W-1:0];
    assign cfg_tag = bus.cfg_din[TAG_W+CNT_W-1:CNT_W];
    assign cfg_len = bus.cfg_din[CNT_W-1:0];

    for (genvar f = 0; f < FLUX; f++) begin : g_flow
        logic [CNT_W-1:0] len_q;
        logic [CNT_W-1:0] remain_q;

        assign accept[f]  = bus.wr_write && (wr_tag == TAG_W'(f)) && !full[f];
        assign cfg_hit[f] = bus.cfg_write && (cfg_tag == TAG_W'(f));

        flow_fifo #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (accept[f]),
            .din   (wr_data),
            .pop   (bus.rd_read[f]),
            .full  (full[f]),
            .empty (empty[f]),
            .head  (head[f])
        );

        // A config write on the same cycle as an accept restarts the frame.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                len_q     <= '0;
                remain_q  <= '0;
                done_q[f] <= 1'b0;
            end else if (cfg_hit[f]) begin
                len_q     <= cfg_len;
                remain_q  <= cfg_len;
                done_q[f] <= 1'b0;
            end else if (accept[f] && (len_q != '0)) begin
                if (remain_q == CNT_W'(1)) begin
                    remain_q  <= len_q;
                    done_q[f] <= 1'b1;
                end else begin
                    remain_q  <= remain_q - 1'b1;
                    done_q[f] <= 1'b0;
                end
            end else begin
                done_q[f] <= 1'b0;
            end
        end
    end

    // A write that no flow accepted was either mis-tagged or aimed at a full flow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((bus.wr_write && (accept == '0)) ||
                     (bus.cfg_write && (cfg_hit == '0))) begin
            err_q <= 1'b1;
        end
    end

    assign bus.wr_full    = full;
    assign bus.rd_empty   = empty;
    assign bus.rd_dout    = head;
    assign bus.frame_done = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_flow_demux_reader.sv
// tb/tb_flow_demux_reader.sv - randomized and directed bench with queue-based reference model
module tb_flow_demux_reader;
    localparam int FLUX  = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 16;
    localparam int TW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    flow_demux_reader_if #(.DATA_W(DW), .FLUX(FLUX), .CNT_W(CW), .TAG_W(TW)) bus ();

    flow_demux_reader #(
        .DATA_W (DW),
        .FLUX   (FLUX),
        .DEPTH  (DEPTH),
        .CNT_W  (CW),
        .TAG_W  (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]      mq [FLUX][$];
    int              mlen [FLUX];
    int              mrem [FLUX];
    logic [FLUX-1:0] mdone;
    logic            merr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queues per flow, evaluated once per rising edge.
    always @(posedge clk or posedge rst) begin
        int              t;
        int              ct;
        logic [FLUX-1:0] acc;
        logic [FLUX-1:0] nd;
        if (rst) begin
            for (int f = 0; f < FLUX; f++) begin
                mq[f].delete();
                mlen[f] = 0;
                mrem[f] = 0;
            end
            mdone = '0;
            merr  = 1'b0;
        end else begin
            acc = '0;
            nd  = '0;
            t   = int'(bus.wr_din[DW+TW-1:DW]);
            ct  = int'(bus.cfg_din[CW+TW-1:CW]);
            if (bus.wr_write) begin
                if (t < FLUX && mq[t].size() < DEPTH) acc[t] = 1'b1;
                else merr = 1'b1;
            end
            for (int f = 0; f < FLUX; f++)
                if (bus.rd_read[f] && mq[f].size() > 0) void'(mq[f].pop_front());
            for (int f = 0; f < FLUX; f++)
                if (acc[f]) mq[f].push_back(bus.wr_din[DW-1:0]);
            if (bus.cfg_write) begin
                if (ct < FLUX) begin
                    mlen[ct] = int'(bus.cfg_din[CW-1:0]);
                    mrem[ct] = mlen[ct];
                end else begin
                    merr = 1'b1;
                end
            end
            for (int f = 0; f < FLUX; f++) begin
                if (acc[f] && !(bus.cfg_write && ct == f) && mlen[f] != 0) begin
                    mrem[f] = mrem[f] - 1;
                    if (mrem[f] == 0) begin
                        nd[f]   = 1'b1;
                        mrem[f] = mlen[f];
                    end
                end
            end
            mdone = nd;
        end
    end

    always @(negedge clk) begin
        for (int f = 0; f < FLUX; f++) begin
            chk($sformatf("empty%0d", f), 64'(bus.rd_empty[f]), 64'(mq[f].size() == 0));
            chk($sformatf("full%0d", f), 64'(bus.wr_full[f]), 64'(mq[f].size() == DEPTH));
            if (mq[f].size() > 0)
                chk($sformatf("dout%0d", f), 64'(bus.rd_dout[f*DW +: DW]), 64'(mq[f][0]));
        end
        chk("frame_done", 64'(bus.frame_done), 64'(mdone));
        chk("err", 64'(bus.err), 64'(merr));
    end

    task automatic cyc(input bit w, input int tag, input int d, input bit cw,
                       input int ctag, input int clen, input logic [FLUX-1:0] rr);
        logic [TW-1:0] tg;
        logic [TW-1:0] ctg;
        tg            = tag[TW-1:0];
        ctg           = ctag[TW-1:0];
        bus.wr_write  = w;
        bus.wr_din    = {tg, d[DW-1:0]};
        bus.cfg_write = cw;
        bus.cfg_din   = {ctg, clen[CW-1:0]};
        bus.rd_read   = rr;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [FLUX-1:0] rr);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, rr);
    endtask

    initial begin
        int c0;
        int c1;
        int idx;
        bus.wr_write  = 1'b0;
        bus.wr_din    = '0;
        bus.cfg_write = 1'b0;
        bus.cfg_din   = '0;
        bus.rd_read   = '0;
        repeat (2) @(negedge clk);
        chk("rst_empty", 64'(bus.rd_empty), 64'h7);
        chk("rst_full", 64'(bus.wr_full), 64'h0);
        chk("rst_dout", 64'(bus.rd_dout), 64'h0);
        chk("rst_done", 64'(bus.frame_done), 64'h0);
        chk("rst_err", 64'(bus.err), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        cyc(1, 0, 'h11, 0, 0, 0, '0);
        cyc(1, 1, 'h22, 0, 0, 0, '0);
        chk("two_empty", 64'(bus.rd_empty), 64'h4);
        chk("two_dout0", 64'(bus.rd_dout[7:0]), 64'h11);
        chk("two_dout1", 64'(bus.rd_dout[15:8]), 64'h22);
        chk("two_err", 64'(bus.err), 64'h0);
        cyc(0, 0, 0, 0, 0, 0, 3'b011);

        for (int i = 0; i < 16; i++) cyc(1, 0, i, 0, 0, 0, '0);
        chk("fill_full", 64'(bus.wr_full), 64'h1);
        cyc(1, 0, 'hEE, 0, 0, 0, '0);
        chk("over_err", 64'(bus.err), 64'h1);
        chk("over_full", 64'(bus.wr_full), 64'h1);
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", 64'(bus.rd_dout[7:0]), 64'(i));
            cyc(0, 0, 0, 0, 0, 0, 3'b001);
        end
        chk("drain_empty", 64'(bus.rd_empty[0]), 64'h1);

        cyc(0, 0, 0, 1, 1, 64, '0);
        cyc(0, 0, 0, 1, 0, 1024, '0);
        c0 = 0; c1 = 0; idx = -1;
        for (int i = 0; i < 128; i++) begin
            cyc(1, i % 2, i, 0, 0, 0, 3'b111);
            if (bus.frame_done[1]) begin c1++; idx = i; end
            if (bus.frame_done[0]) c0++;
        end
        chk("f1_pulses", 64'(c1), 64'd1);
        chk("f1_pulse_idx", 64'(idx), 64'd127);
        for (int i = 64; i < 1024; i++) begin
            chk("f0_no_early", 64'(c0), 64'd0);
            cyc(1, 0, i, 0, 0, 0, 3'b111);
            if (bus.frame_done[0]) c0++;
        end
        chk("f0_pulses", 64'(c0), 64'd1);
        idle(2, 3'b111);

        cyc(0, 0, 0, 1, 2, 5, '0);
        cyc(1, 2, 'h01, 0, 0, 0, 3'b100);
        cyc(1, 2, 'h02, 1, 2, 3, 3'b100);
        chk("cfg_win_done", 64'(bus.frame_done[2]), 64'h0);
        cyc(1, 2, 'h03, 0, 0, 0, 3'b100);
        chk("cfg_w1", 64'(bus.frame_done[2]), 64'h0);
        cyc(1, 2, 'h04, 0, 0, 0, 3'b100);
        chk("cfg_w2", 64'(bus.frame_done[2]), 64'h0);
        cyc(1, 2, 'h05, 0, 0, 0, 3'b100);
        chk("cfg_w3", 64'(bus.frame_done[2]), 64'h1);
        cyc(0, 0, 0, 1, 2, 0, 3'b100);

        for (int i = 0; i < 5; i++) cyc(1, 2, 'hA0 + i, 0, 0, 0, '0);
        cyc(1, 2, 'h55, 0, 0, 0, 3'b100);
        chk("pp_head", 64'(bus.rd_dout[23:16]), 64'hA1);
        chk("pp_full", 64'(bus.wr_full[2]), 64'h0);
        idle(5, 3'b100);
        chk("pp_empty", 64'(bus.rd_empty[2]), 64'h1);
        cyc(1, 2, 'h66, 0, 0, 0, 3'b100);
        chk("ep_empty", 64'(bus.rd_empty[2]), 64'h0);
        chk("ep_dout", 64'(bus.rd_dout[23:16]), 64'h66);
        idle(1, 3'b100);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) != 0, $urandom % 4, $urandom % 256,
                ($urandom % 32) == 0, $urandom % 4, $urandom % 6,
                3'($urandom % 8) & 3'($urandom % 8));
        end

        idle(DEPTH, 3'b111);
        cyc(0, 0, 0, 1, 0, 10, '0);
        for (int i = 0; i < 7; i++) cyc(1, 0, 'h30 + i, 0, 0, 0, '0);
        chk("pre_rst_empty", 64'(bus.rd_empty[0]), 64'h0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_empty", 64'(bus.rd_empty), 64'h7);
        chk("mid_rst_done", 64'(bus.frame_done), 64'h0);
        chk("mid_rst_err", 64'(bus.err), 64'h0);
        chk("mid_rst_dout", 64'(bus.rd_dout), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 1, 0, 2, '0);
        cyc(1, 0, 'h77, 0, 0, 0, '0);
        chk("fresh_no_done", 64'(bus.frame_done[0]), 64'h0);
        cyc(1, 0, 'h78, 0, 0, 0, '0);
        chk("fresh_done", 64'(bus.frame_done[0]), 64'h1);
        chk("fresh_head", 64'(bus.rd_dout[7:0]), 64'h77);
        idle(2, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
